// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO.
package sync_fifo_pkg;

  localparam string FT_TRUE  = "TRUE";
  localparam string FT_FALSE = "FALSE";

  // Ceiling log2, used only for elaboration-time parameter checks.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATASIZE storage: one write port and one read port.
// The read port is combinational (fall-through) or loaded on an accepted read.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int    DATASIZE    = 8,
  parameter int    ADDRSIZE    = 4,
  parameter string FALLTHROUGH = "TRUE"
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                re,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [DATASIZE-1:0] rdata
);

  localparam int DEPTH = 1 << ADDRSIZE;

  logic [DATASIZE-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset so it can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  if (FALLTHROUGH == FT_TRUE) begin : g_ft
    logic unused_ft;
    assign unused_ft = rst ^ re;
    assign rdata     = mem_q[raddr];
  end else begin : g_reg
    logic [DATASIZE-1:0] rdata_q;
    logic [DATASIZE-1:0] rdata_d;

    always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = mem_q[raddr];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: binary pointers, registered occupancy count and flags,
// programmable almost-full/almost-empty and one-cycle overflow/underflow pulses.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int    DATASIZE    = 8,
  parameter int    ADDRSIZE    = 4,
  parameter string FALLTHROUGH = "TRUE",
  parameter int    AWFULL_TH   = 2,
  parameter int    AREMPTY_TH  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                winc,
  input  logic [DATASIZE-1:0] wdata,
  output logic                wfull,
  output logic                awfull,
  input  logic                rinc,
  output logic [DATASIZE-1:0] rdata,
  output logic                rempty,
  output logic                arempty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam int              DEPTH   = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] DEPTH_C = (ADDRSIZE + 1)'(DEPTH);
  localparam logic [ADDRSIZE:0] AWF_C   = (ADDRSIZE + 1)'(AWFULL_TH);
  localparam logic [ADDRSIZE:0] ARE_C   = (ADDRSIZE + 1)'(AREMPTY_TH);
  localparam logic [ADDRSIZE:0] ONE     = 1;

  if (AWFULL_TH < 1 || AWFULL_TH >= DEPTH || clog2(AWFULL_TH + 1) > ADDRSIZE) begin : g_bad_awf
    $error("sync_fifo: AWFULL_TH=%0d outside 1..%0d", AWFULL_TH, DEPTH - 1);
  end
  if (AREMPTY_TH < 1 || AREMPTY_TH >= DEPTH || clog2(AREMPTY_TH + 1) > ADDRSIZE) begin : g_bad_are
    $error("sync_fifo: AREMPTY_TH=%0d outside 1..%0d", AREMPTY_TH, DEPTH - 1);
  end
  if (FALLTHROUGH != FT_TRUE && FALLTHROUGH != FT_FALSE) begin : g_bad_ft
    $error("sync_fifo: FALLTHROUGH must be TRUE or FALSE");
  end

  logic [ADDRSIZE:0] wptr_q, wptr_d;
  logic [ADDRSIZE:0] rptr_q, rptr_d;
  logic [ADDRSIZE:0] count_q, count_d;
  logic              wfull_q, wfull_d;
  logic              rempty_q, rempty_d;
  logic              awfull_q, awfull_d;
  logic              arempty_q, arempty_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_acc;
  logic              rd_acc;

  // Acceptance uses the registered flags, so a full FIFO rejects a write even
  // when a read frees a slot on the same edge (and symmetrically when empty).
  always_comb begin
    wr_acc      = winc & ~wfull_q;
    rd_acc      = rinc & ~rempty_q;
    wptr_d      = wr_acc ? wptr_q + ONE : wptr_q;
    rptr_d      = rd_acc ? rptr_q + ONE : rptr_q;
    count_d     = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
    wfull_d     = (count_d == DEPTH_C);
    rempty_d    = (count_d == '0);
    awfull_d    = ((DEPTH_C - count_d) <= AWF_C);
    arempty_d   = (count_d <= ARE_C);
    overflow_d  = winc & wfull_q;
    underflow_d = rinc & rempty_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      wfull_q     <= 1'b0;
      rempty_q    <= 1'b1;
      awfull_q    <= 1'b0;
      arempty_q   <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      wfull_q     <= wfull_d;
      rempty_q    <= rempty_d;
      awfull_q    <= awfull_d;
      arempty_q   <= arempty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Wrap bits are kept for a natural modulo-2*DEPTH pointer but flags come from count.
  logic unused_wrap;
  assign unused_wrap = wptr_q[ADDRSIZE] ^ rptr_q[ADDRSIZE];

  sync_fifo_mem #(
    .DATASIZE   (DATASIZE),
    .ADDRSIZE   (ADDRSIZE),
    .FALLTHROUGH(FALLTHROUGH)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_acc),
    .waddr(wptr_q[ADDRSIZE-1:0]),
    .wdata(wdata),
    .re   (rd_acc),
    .raddr(rptr_q[ADDRSIZE-1:0]),
    .rdata(rdata)
  );

  assign count     = count_q;
  assign wfull     = wfull_q;
  assign rempty    = rempty_q;
  assign awfull    = awfull_q;
  assign arempty   = arempty_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Two FIFOs (fall-through with thresholds 2/2, registered with 4/3) share one
// stimulus stream and are compared every cycle against a queue-based model.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       winc = 1'b0;
  logic       rinc = 1'b0;
  logic [7:0] wdata = '0;

  logic [7:0] ft_rdata, rg_rdata;
  logic [4:0] ft_count, rg_count;
  logic ft_wfull, ft_awfull, ft_rempty, ft_arempty, ft_ovf, ft_udf;
  logic rg_wfull, rg_awfull, rg_rempty, rg_arempty, rg_ovf, rg_udf;

  sync_fifo u_ft (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .wfull(ft_wfull), .awfull(ft_awfull),
    .rinc(rinc), .rdata(ft_rdata), .rempty(ft_rempty), .arempty(ft_arempty), .count(ft_count),
    .overflow(ft_ovf), .underflow(ft_udf)
  );

  sync_fifo #(.FALLTHROUGH("FALSE"), .AWFULL_TH(4), .AREMPTY_TH(3)) u_rg (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .wfull(rg_wfull), .awfull(rg_awfull),
    .rinc(rinc), .rdata(rg_rdata), .rempty(rg_rempty), .arempty(rg_arempty), .count(rg_count),
    .overflow(rg_ovf), .underflow(rg_udf)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         q[$];
  logic [7:0] rg_exp = '0;
  bit         ovf_exp = 1'b0;
  bit         udf_exp = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check_eq("ft_count",   32'(ft_count),   32'(n));
    check_eq("ft_wfull",   32'(ft_wfull),   32'(n == 16));
    check_eq("ft_rempty",  32'(ft_rempty),  32'(n == 0));
    check_eq("ft_awfull",  32'(ft_awfull),  32'((16 - n) <= 2));
    check_eq("ft_arempty", 32'(ft_arempty), 32'(n <= 2));
    check_eq("ft_ovf",     32'(ft_ovf),     32'(ovf_exp));
    check_eq("ft_udf",     32'(ft_udf),     32'(udf_exp));
    if (n > 0) check_eq("ft_rdata", 32'(ft_rdata), 32'(q[0]));
    check_eq("rg_count",   32'(rg_count),   32'(n));
    check_eq("rg_wfull",   32'(rg_wfull),   32'(n == 16));
    check_eq("rg_rempty",  32'(rg_rempty),  32'(n == 0));
    check_eq("rg_awfull",  32'(rg_awfull),  32'((16 - n) <= 4));
    check_eq("rg_arempty", 32'(rg_arempty), 32'(n <= 3));
    check_eq("rg_ovf",     32'(rg_ovf),     32'(ovf_exp));
    check_eq("rg_udf",     32'(rg_udf),     32'(udf_exp));
    check_eq("rg_rdata",   32'(rg_rdata),   32'(rg_exp));
  endtask

  // One clock: drive inputs, update the model from the pre-edge occupancy, check.
  task automatic step(input bit w, input bit r, input logic [7:0] d);
    bit full;
    bit empty;
    full  = (q.size() == 16);
    empty = (q.size() == 0);
    winc  = w;
    rinc  = r;
    wdata = d;
    @(posedge clk);
    ovf_exp = w && full;
    udf_exp = r && empty;
    if (r && !empty) begin
      rg_exp = 8'(q[0]);
      void'(q.pop_front());
    end
    if (w && !full) q.push_back(int'(d));
    #1;
    check_all();
  endtask

  initial begin
    #12;
    check_all();
    @(negedge clk) rst = 1'b0;
    repeat (3) step(1'b0, 1'b0, 8'h00);

    // Asynchronous reset in the middle of a fill
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h50 + i));
    check_eq("prefill_count", 32'(ft_count), 32'd5);
    #2 rst = 1'b1;
    #1;
    check_eq("async_count",  32'(ft_count),  32'd0);
    check_eq("async_rempty", 32'(rg_rempty), 32'd1);
    q.delete();
    rg_exp  = '0;
    ovf_exp = 1'b0;
    udf_exp = 1'b0;
    check_all();
    @(negedge clk) rst = 1'b0;
    step(1'b0, 1'b0, 8'h00);

    // Fill 0x00..0x0F, overflow with 0xAA, drain in order, underflow
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i));
    check_eq("full_count", 32'(rg_count), 32'd16);
    step(1'b1, 1'b0, 8'hAA);
    check_eq("ovf_pulse", 32'(ft_ovf), 32'd1);
    step(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check_eq("rg_order", 32'(rg_rdata), 32'(i));
    end
    step(1'b0, 1'b1, 8'h00);
    check_eq("udf_pulse", 32'(rg_udf), 32'd1);
    step(1'b0, 1'b0, 8'h00);

    // Simultaneous read/write at count 7, at full and at empty
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'($urandom));
    check_eq("simul_7", 32'(ft_count), 32'd7);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'($urandom));
    step(1'b1, 1'b1, 8'h3C);
    check_eq("simul_full", 32'(ft_count), 32'd15);
    while (q.size() > 0) step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'hC3);
    check_eq("simul_empty", 32'(rg_count), 32'd1);
    step(1'b0, 1'b1, 8'h00);

    // Randomised traffic, alternating write-heavy and read-heavy phases
    for (int c = 0; c < 1000; c++) begin
      int pw;
      pw = ((c / 60) % 2 == 0) ? 75 : 30;
      step(($urandom_range(99) < pw), ($urandom_range(99) < (100 - pw)), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
